// File: rtl/flag_unit_if.sv
// Bus between an ALU datapath and the flag/condition unit.
// The master drives the ALU outputs and requests; the slave returns zero, flags and the evaluation result.
interface flag_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             set_flags;
    logic             cond_check;
    logic [3:0]       cond;
    logic             cbz;
    logic             zero;
    logic [3:0]       flags;
    logic             take_valid;
    logic             taken;

    modport master (
        output result,
        output alu_carry,
        output alu_overflow,
        output set_flags,
        output cond_check,
        output cond,
        output cbz,
        input  zero,
        input  flags,
        input  take_valid,
        input  taken
    );

    modport slave (
        input  result,
        input  alu_carry,
        input  alu_overflow,
        input  set_flags,
        input  cond_check,
        input  cond,
        input  cbz,
        output zero,
        output flags,
        output take_valid,
        output taken
    );
endinterface

// File: rtl/flag_unit.sv
// NZCV flag register with single-cycle condition evaluation (including CBZ/CBNZ).
// A set_flags in the same cycle as a request bypasses the register so the request sees the new flags.
module flag_unit #(
    parameter int WIDTH = 64
) (
    input logic   clk,
    input logic   reset,
    flag_if.slave fu
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic       live_z;
    logic [3:0] live_flags;
    logic [3:0] eval_flags;
    logic       cond_true;
    logic       outcome;

    logic [3:0] flags_q,      flags_d;
    logic       take_valid_q, take_valid_d;
    logic       taken_q,      taken_d;

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        {n, z, cy, v} = f;
        case (c)
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_HS: res = cy;
            COND_LO: res = !cy;
            COND_MI: res = n;
            COND_PL: res = !n;
            COND_VS: res = v;
            COND_VC: res = !v;
            COND_HI: res = cy & !z;
            COND_LS: res = !cy | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = !z & (n == v);
            COND_LE: res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    assign live_z     = ~|fu.result;
    assign live_flags = {fu.result[WIDTH-1], live_z, fu.alu_carry, fu.alu_overflow};
    assign eval_flags = fu.set_flags ? live_flags : flags_q;
    assign cond_true  = eval_cond(fu.cond, eval_flags);

    // CBZ/CBNZ looks only at the live zero; cond[0] picks the polarity.
    assign outcome = fu.cbz ? (fu.cond[0] ? !live_z : live_z) : cond_true;

    always_comb begin
        flags_d      = flags_q;
        take_valid_d = fu.cond_check;
        taken_d      = fu.cond_check & outcome;
        if (fu.set_flags) begin
            flags_d = live_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            take_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            take_valid_q <= take_valid_d;
            taken_q      <= taken_d;
        end
    end

    assign fu.zero       = live_z;
    assign fu.flags      = flags_q;
    assign fu.take_valid = take_valid_q;
    assign fu.taken      = taken_q;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, the ALU result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 result  input  WIDTH  ALU result for the current cycle.
REQ-005 alu_carry  input  1  ALU carry-out for the current cycle.
REQ-006 alu_overflow  input  1  ALU signed overflow for the current cycle.
REQ-007 set_flags  input  1  when high, N/Z/C/V are loaded from the current ALU outputs at the clock edge.
REQ-008 cond_check  input  1  evaluation request for the current cycle.
REQ-009 cond  input  4  condition code: EQ 0000, NE 0001, HS 0010, LO 0011, MI 0100, PL 0101, VS 0110, VC 0111, HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110, NV 1111.
REQ-010 cbz  input  1  when high, the request is a compare-and-branch on result; cond[0]=0 selects CBZ and cond[0]=1 selects CBNZ.
REQ-011 zero  output  1  combinational; high iff result is all zeros.
REQ-012 flags  output  4  registered {N,Z,C,V}.
REQ-013 take_valid  output  1  registered; high for one cycle per accepted request.
REQ-014 taken  output  1  registered; evaluation outcome, qualified by take_valid.

Function
REQ-015 zero SHALL equal the NOR-reduction of all WIDTH bits of result, with no clock latency.
REQ-016 Live flags SHALL be: N = result[WIDTH-1]; Z = zero; C = alu_carry; V = alu_overflow.
REQ-017 On a clock edge with set_flags=1, flags SHALL load the live flags; with set_flags=0, flags SHALL hold.
REQ-018 Evaluation flags SHALL be the live flags when set_flags=1 in the same cycle as cond_check (bypass), and the stored flags otherwise.
REQ-019 Conditions: EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL and NV always 1.
REQ-020 With cbz=1, evaluation SHALL ignore all flags: CBZ taken = zero; CBNZ taken = !zero; cond[3:1] are ignored.
REQ-021 Latency: a request sampled at edge k SHALL produce take_valid=1 and its taken value in the cycle following edge k.
REQ-022 Without a request at edge k, take_valid SHALL be 0 and taken SHALL be 0 in the following cycle.
REQ-023 Requests on consecutive cycles SHALL each be accepted; take_valid then stays high continuously, and taken is updated every cycle.
REQ-024 cond_check SHALL NOT alter flags; set_flags SHALL NOT generate take_valid.
REQ-025 There SHALL be no stall, backpressure or busy state; every request is accepted.

Reset
REQ-026 While reset=1, flags SHALL be 4'b0000 and take_valid and taken SHALL be 0, asynchronously and independent of clk.
REQ-027 A request sampled at the same edge at which reset is high SHALL be discarded, with no take_valid after reset deasserts.
REQ-028 After reset deasserts, requests made before any set_flags SHALL evaluate against flags 0000; for example, EQ evaluates not-taken and PL evaluates taken.

Verification
REQ-029 Async reset: run traffic, then assert reset between edges -> flags=0000, take_valid=0 and taken=0 before the next rising edge.
REQ-030 Flag load: result=0, alu_carry=1, alu_overflow=0, set_flags=1 -> next cycle flags=4'b0110; zero=1 in the same cycle.
REQ-031 Bypass: result=64'h8000_0000_0000_0000, alu_overflow=0, set_flags=1, cond_check=1, cond=LT -> next cycle take_valid=1, taken=1, flags=4'b1000.
REQ-032 Stored flags: Z stored as 1, then result=5, set_flags=0, cond_check=1, cond=EQ -> taken=1 and flags unchanged; the same request with cond=NE -> taken=0.
REQ-033 CBZ/CBNZ: cbz=1, cond=0000, result=0 -> taken=1; result=5 -> taken=0; cond=0001, result=5 -> taken=1; stored flags unchanged in all three cases.
REQ-034 Back-to-back: cond_check=1 for 3 cycles with cond=AL, then NV, then GT (with Z=1) -> take_valid high for 3 consecutive cycles, with taken 1, then 1, then 0, and take_valid=0 on the following cycle.
